matrix_frame_writer: RTL and testbench
======================================

Name: matrix_frame_writer

Overview:
- Wishbone master that sits directly upstream of the 8x8 RGB matrix driver's slave port.
- Accepts a raster pixel stream of 4-bit xRGB nibbles, 64 pixels per frame, row-major, column 0 first.
- Packs each group of 8 pixels into one 32-bit row word and writes it to driver register 0..7.
- Reports frame completion and framing or bus errors.

Parameters:
- WB_DATA_WIDTH, 32, bus data width; only 32 is supported.
- ROW_COUNT, 8, rows per frame; also the number of pixels per row.
- WB_ADDR_WIDTH, $clog2(ROW_COUNT), width of the register address.
- WB_SEL_WIDTH, WB_DATA_WIDTH/8, width of the byte-select.
- ACK_TIMEOUT, 16, cycles to wait for i_wb_ack before abandoning a transfer.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- i_pix_valid  in  1  pixel stream valid.
- i_pix_data  in  4  pixel as 0bxRGB (bit3 ignored, stored as written).
- i_pix_last  in  1  marks the final pixel of a frame.
- o_pix_ready  out  1  pixel stream ready.
- o_busy  out  1  high whenever not in COLLECT with an empty row.
- o_frame_done  out  1  one-cycle pulse after the row 7 write completes (or the frame is cut short).
- o_frame_err  out  1  one-cycle pulse on a framing, timeout or readback error.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master controls.
- o_wb_addr  out  WB_ADDR_WIDTH  row register index.
- o_wb_sel  out  WB_SEL_WIDTH  byte select; always all-ones.
- o_wb_wdata  out  WB_DATA_WIDTH  packed row word.
- i_wb_ack, i_wb_stall  in  1 each  slave handshake.
- i_wb_rdata  in  WB_DATA_WIDTH  read data; used only with the optional feature.

Behaviour:
- Reset (async assert, sync release):
  - state=COLLECT, column=0, row=0, row word=0.
  - o_pix_ready=1; all other outputs 0 (o_wb_sel=0 in reset, all-ones once a cycle starts).
- Handshake: a pixel is accepted when i_pix_valid && o_pix_ready. o_pix_ready=1 only in COLLECT.
- Packing:
  - Pixel at column c goes to word bits [4*(7-c)+3 : 4*(7-c)], so column 0 is in bits [31:28].
  - The column counter increments per accepted pixel and wraps 7->0.
- COLLECT -> WRITE:
  - Transition on acceptance of column 7, or of an early i_pix_last.
  - On an early last, unfilled nibbles are 0.
  - Registered: o_wb_cyc=o_wb_stb=o_wb_we=1, o_wb_addr=row and o_wb_wdata=word on the cycle after acceptance (latency 1).
- WRITE: hold stb, addr and data stable while i_wb_stall=1. When stall=0 the request is taken: stb drops next cycle, go to WAIT_ACK.
- WAIT_ACK:
  - cyc stays high.
  - On i_wb_ack: drop cyc, row++, clear the word, go to COLLECT (or DONE if row was 7 or the frame was terminated by last).
  - An ack arriving in the same cycle the request is taken is legal and handled identically.
- Timeout: a counter runs from entry to WRITE. At ACK_TIMEOUT cycles without ack, drop cyc and stb, pulse o_frame_err, and advance as if acked.
- DONE: for one cycle pulse o_frame_done, reset row=0, then return to COLLECT.
- Framing errors (pulse o_frame_err):
  - i_pix_last on a pixel other than pixel 63 (row 7, col 7): remaining rows are not written; o_frame_done still pulses.
  - Pixel 63 without last: the frame completes normally plus the error pulse; the next pixel starts row 0.
- Error and done pulses coinciding are allowed.
- Reset asserted mid-transaction: cyc and stb drop immediately (asynchronously). The partial frame is discarded.

Optional Feature:
- Macro: MATRIX_FRAME_READBACK_EN.
- Defined:
  - After each write ack, issue a read (we=0) to the same address with the same stall/ack/timeout rules.
  - Compare i_wb_rdata to the written word; on mismatch pulse o_frame_err.
  - Adds states RSTB and RWAIT.
- Undefined: no reads are ever issued, and i_wb_rdata is unused.

Test Plan:
- Ideal slave (stall=0, ack 1 cycle after stb), 64 pixels with value (p%8)+1 and last on pixel 63 -> eight writes, each o_wb_wdata=32'h12345678, addr 0..7, sel 4'hF, one o_frame_done pulse, no error.
- i_wb_stall held high 5 cycles on row 3 -> stb, addr=3 and data stable across all stalled cycles, exactly one transfer, the following rows are correct.
- Slave never acks on row 2 -> cyc drops after 16 cycles, one o_frame_err pulse, row 3 written next.
- i_pix_last on pixel 10 (row 1, col 2) -> row 1 word = pix8,pix9,pix10 in bits [31:20], lower nibbles 0, o_frame_err and o_frame_done pulse, the next pixel goes to row 0.
- reset_n low while o_wb_cyc=1 -> cyc and stb go low without waiting for clk, o_pix_ready=1 after release, the next frame starts at addr 0.
- With MATRIX_FRAME_READBACK_EN, slave returns rdata XOR 1 -> a read follows each write to the same address, o_frame_err pulses per row.

Source files
------------

// File: rtl/matrix_frame_writer.sv
// Wishbone master that packs a 64-pixel xRGB raster into eight 32-bit row words for the matrix
// driver. Define MATRIX_FRAME_READBACK_EN to read each row back and verify it after the write.
module matrix_frame_writer #(
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned ROW_COUNT     = 8,
    parameter int unsigned WB_ADDR_WIDTH = $clog2(ROW_COUNT),
    parameter int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int unsigned ACK_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_pix_valid,
    input  logic [3:0]               i_pix_data,
    input  logic                     i_pix_last,
    output logic                     o_pix_ready,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_frame_err,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
    output logic [WB_SEL_WIDTH-1:0]  o_wb_sel,
    output logic [WB_DATA_WIDTH-1:0] o_wb_wdata,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    input  logic [WB_DATA_WIDTH-1:0] i_wb_rdata
);
    localparam int unsigned TimerWidth = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WB_ADDR_WIDTH-1:0] LastIdx = WB_ADDR_WIDTH'(ROW_COUNT - 1);
    localparam logic [TimerWidth-1:0] TimerMax = TimerWidth'(ACK_TIMEOUT - 1);

`ifdef MATRIX_FRAME_READBACK_EN
    typedef enum logic [2:0] {StCollect, StWrite, StWaitAck, StDone, StRstb, StRwait} state_e;
`else
    typedef enum logic [1:0] {StCollect, StWrite, StWaitAck, StDone} state_e;
`endif

    state_e state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] col_q, row_q, addr_q;
    logic [WB_DATA_WIDTH-1:0] word_q, word_next, wdata_q;
    logic [TimerWidth-1:0] timer_q;
    logic last_q, sel_on_q, err_q;
    logic accept, row_end, frame_err, frame_over;
    logic req, wait_st, taken, ack_ok, timeout;
    logic advance, bus_err, timer_clr;

    assign accept     = i_pix_valid && (state_q == StCollect);
    assign row_end    = accept && (i_pix_last || col_q == LastIdx);
    // Last must land exactly on the final pixel of the final row.
    assign frame_err  = accept && (i_pix_last != (row_q == LastIdx && col_q == LastIdx));
    assign frame_over = last_q || (row_q == LastIdx);

`ifdef MATRIX_FRAME_READBACK_EN
    assign req     = (state_q == StWrite) || (state_q == StRstb);
    assign wait_st = (state_q == StWaitAck) || (state_q == StRwait);
`else
    assign req     = (state_q == StWrite);
    assign wait_st = (state_q == StWaitAck);
    logic unused_rdata;
    assign unused_rdata = ^i_wb_rdata;
`endif

    assign taken   = req && !i_wb_stall;
    assign ack_ok  = i_wb_ack && (taken || wait_st);
    assign timeout = (req || wait_st) && (timer_q == TimerMax);

    always_comb begin
        word_next = word_q;
        word_next[WB_DATA_WIDTH - 1 - 4 * int'(col_q) -: 4] = i_pix_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        bus_err = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (row_end) state_d = StWrite;
            end
            StWrite, StWaitAck: begin
                if (ack_ok || timeout) begin
                    bus_err = !ack_ok;
`ifdef MATRIX_FRAME_READBACK_EN
                    state_d = StRstb;
`else
                    advance = 1'b1;
                    state_d = frame_over ? StDone : StCollect;
`endif
                end else if (taken) begin
                    state_d = StWaitAck;
                end
            end
`ifdef MATRIX_FRAME_READBACK_EN
            StRstb, StRwait: begin
                if (ack_ok || timeout) begin
                    bus_err = !ack_ok || (i_wb_rdata != wdata_q);
                    advance = 1'b1;
                    state_d = frame_over ? StDone : StCollect;
                end else if (taken) begin
                    state_d = StRwait;
                end
            end
`endif
            StDone:  state_d = StCollect;
            default: state_d = StCollect;
        endcase
    end

    // The ack timer restarts at the start of every bus request (write, and read if enabled).
    always_comb begin
        timer_clr = !(req || wait_st);
`ifdef MATRIX_FRAME_READBACK_EN
        if (state_d == StRstb && state_q != StRstb) timer_clr = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            wdata_q  <= '0;
            timer_q  <= '0;
            last_q   <= 1'b0;
            sel_on_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q   <= frame_err || bus_err;
            timer_q <= timer_clr ? '0 : timer_q + 1'b1;
            if (accept) begin
                if (row_end) begin
                    word_q   <= '0;
                    col_q    <= '0;
                    wdata_q  <= word_next;
                    addr_q   <= row_q;
                    last_q   <= i_pix_last;
                    sel_on_q <= 1'b1;
                end else begin
                    word_q <= word_next;
                    col_q  <= col_q + 1'b1;
                end
            end
            if (advance) row_q <= row_q + 1'b1;
            if (state_q == StDone) begin
                row_q  <= '0;
                last_q <= 1'b0;
            end
        end
    end

    always_comb begin
        o_pix_ready  = (state_q == StCollect);
        o_busy       = !((state_q == StCollect) && (col_q == '0));
        o_frame_done = (state_q == StDone);
        o_wb_cyc     = req || wait_st;
        o_wb_stb     = req;
        o_wb_we      = (state_q == StWrite) || (state_q == StWaitAck);
    end

    assign o_frame_err = err_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_wdata  = wdata_q;
    assign o_wb_sel    = {WB_SEL_WIDTH{sel_on_q}};

endmodule

// File: tb/tb_matrix_frame_writer.sv
// Randomized bench for matrix_frame_writer: a frame-level reference model plus a behavioural
// Wishbone slave, with all checks made from one per-cycle compare task.
module tb_matrix_frame_writer;
    localparam int Tmo = 16;
`ifdef MATRIX_FRAME_READBACK_EN
    localparam int RbErr = 1;
`else
    localparam int RbErr = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_pix_valid = 1'b0;
    logic [3:0]  i_pix_data = 4'h0;
    logic        i_pix_last = 1'b0;
    logic        o_pix_ready, o_busy, o_frame_done, o_frame_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_wdata;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic [31:0] i_wb_rdata = 32'h0;

    always #5 clk = ~clk;

    matrix_frame_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_pix_valid (i_pix_valid),
        .i_pix_data  (i_pix_data),
        .i_pix_last  (i_pix_last),
        .o_pix_ready (o_pix_ready),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_frame_err (o_frame_err),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_we     (o_wb_we),
        .o_wb_addr   (o_wb_addr),
        .o_wb_sel    (o_wb_sel),
        .o_wb_wdata  (o_wb_wdata),
        .i_wb_ack    (i_wb_ack),
        .i_wb_stall  (i_wb_stall),
        .i_wb_rdata  (i_wb_rdata)
    );

    int n_tests = 0;
    int n_fail = 0;

    logic [4:0]  pix_q[$];   // {last, data} waiting to be sent
    logic [34:0] exp_wr[$];  // {addr, word} the model expects on the bus
    int          model_pix = 0;
    logic [31:0] model_word = 32'h0;
    int exp_err = 0, exp_done = 0, got_err = 0, got_done = 0;

    int stall_pct = 0, valid_pct = 100, min_dly = 1, max_dly = 1;
    int noack_addr = -1, stall_addr = -1, stall_len = 0, force_stall = 0;
    bit stall_armed = 0, pending = 0, tmo_pending = 0, prev_stalled = 0;
    int ack_wait = 0, cyc_run = 0;
    logic [2:0]  prev_addr = 3'h0, last_waddr = 3'h0;
    logic [31:0] prev_data = 32'h0, last_wdata = 32'h0;
    logic [2:0]  log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Frame rules: 8 pixels per row word, column 0 in the top nibble, frame ends at last or pixel 63.
    task automatic model_accept(input logic [3:0] d, input logic last);
        int col;
        col = model_pix % 8;
        model_word[31 - 4 * col -: 4] = d;
        if (col == 7 || last) begin
            exp_wr.push_back({3'(model_pix / 8), model_word});
            model_word = 32'h0;
        end
        if (last || model_pix == 63) begin
            exp_done++;
            if (last != (model_pix == 63)) exp_err++;
            model_pix = 0;
        end else begin
            model_pix++;
        end
    endtask

    task automatic schedule_ack();
        int d;
        d = int'($urandom_range(max_dly, min_dly));
        if (d == 0) i_wb_ack = 1'b1;
        else begin
            pending = 1;
            ack_wait = d - 1;
        end
    endtask

    task automatic take_request();
        logic [34:0] e;
        if (o_wb_we) begin
            check("write expected", exp_wr.size() > 0, 1'b1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                check("write addr", o_wb_addr, e[34:32]);
                check("write data", o_wb_wdata, e[31:0]);
            end
            check("write sel", o_wb_sel, 4'hF);
            log_addr.push_back(o_wb_addr);
            log_data.push_back(o_wb_wdata);
            last_wdata = o_wb_wdata;
            last_waddr = o_wb_addr;
            if (int'(o_wb_addr) == noack_addr) begin
                exp_err++;
                tmo_pending = 1;
                pending = 1;
                ack_wait = 1000000;
            end else begin
                schedule_ack();
            end
        end else begin
            check("read addr", o_wb_addr, last_waddr);
            i_wb_rdata = last_wdata ^ 32'h1;
            exp_err++;
            schedule_ack();
        end
    endtask

    // One cycle: check outputs settled after the last edge, then drive inputs for the next edge.
    task automatic tick();
        @(negedge clk);
        if (o_frame_err) got_err++;
        if (o_frame_done) got_done++;
        check("busy", o_busy, !(o_pix_ready && (model_pix % 8 == 0)));
        if (prev_stalled) begin
            check("stall stb held", o_wb_stb, 1'b1);
            check("stall addr held", o_wb_addr, prev_addr);
            check("stall data held", o_wb_wdata, prev_data);
        end
        if (o_wb_cyc) cyc_run++;
        else begin
`ifndef MATRIX_FRAME_READBACK_EN
            if (tmo_pending) check("timeout cyc length", cyc_run, Tmo);
`endif
            tmo_pending = 0;
            cyc_run = 0;
            pending = 0;
        end
        i_wb_ack = 1'b0;
        i_wb_stall = 1'b0;
        if (pending) begin
            if (ack_wait == 0) begin
                i_wb_ack = 1'b1;
                pending = 0;
            end else ack_wait--;
        end
        if (o_wb_stb) begin
`ifndef MATRIX_FRAME_READBACK_EN
            check("stb is write", o_wb_we, 1'b1);
`endif
            if (!stall_armed && o_wb_we && stall_len > 0 && int'(o_wb_addr) == stall_addr) begin
                stall_armed = 1;
                force_stall = stall_len;
            end
            if (force_stall > 0) begin
                i_wb_stall = 1'b1;
                force_stall--;
            end else begin
                i_wb_stall = ($urandom_range(99) < stall_pct);
            end
            if (!i_wb_stall) take_request();
        end
        prev_stalled = o_wb_stb && i_wb_stall;
        prev_addr = o_wb_addr;
        prev_data = o_wb_wdata;
        if (pix_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            i_pix_valid = 1'b1;
            {i_pix_last, i_pix_data} = pix_q[0];
            if (o_pix_ready) begin
                model_accept(pix_q[0][3:0], pix_q[0][4]);
                void'(pix_q.pop_front());
            end
        end else begin
            i_pix_valid = 1'b0;
            i_pix_last = 1'($urandom_range(1));
            i_pix_data = 4'($urandom_range(15));
        end
    endtask

    task automatic start_test();
        exp_err = 0; exp_done = 0; got_err = 0; got_done = 0;
        stall_pct = 0; valid_pct = 100; min_dly = 1; max_dly = 1;
        noack_addr = -1; stall_addr = -1; stall_len = 0; stall_armed = 0; force_stall = 0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic run_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(pix_q.size() == 0 && !i_pix_valid && !o_busy && !o_wb_cyc && !pending)
               && n < budget) begin
            tick();
            n++;
        end
        check({name, " reached idle"}, n < budget, 1'b1);
        repeat (3) tick();
        check({name, " writes drained"}, exp_wr.size(), 0);
        check({name, " err pulses"}, got_err, exp_err);
        check({name, " done pulses"}, got_done, exp_done);
    endtask

    task automatic push_frame_ramp();
        for (int p = 0; p < 64; p++) pix_q.push_back({p == 63, 4'(p % 8 + 1)});
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n3;
        int mode, cut;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ready", o_pix_ready, 1'b1);
        check("reset busy", o_busy, 1'b0);
        check("reset cyc", o_wb_cyc, 1'b0);
        check("reset stb", o_wb_stb, 1'b0);
        check("reset we", o_wb_we, 1'b0);
        check("reset addr", o_wb_addr, 3'h0);
        check("reset sel", o_wb_sel, 4'h0);
        check("reset wdata", o_wb_wdata, 32'h0);
        check("reset done", o_frame_done, 1'b0);
        check("reset err", o_frame_err, 1'b0);
        reset_n = 1'b1;

        // Ideal slave, ramp pattern.
        start_test();
        push_frame_ramp();
        run_idle("ideal", 3000);
        check("ideal write count", log_data.size(), 8);
        check("ideal row0 word", log_data[0], 32'h12345678);
        check("ideal row7 word", log_data[7], 32'h12345678);
        check("ideal row7 addr", log_addr[7], 3'd7);
        check("ideal done literal", got_done, 1);
        check("ideal err literal", got_err, 8 * RbErr);

        // Row 3 stalled for 5 cycles.
        start_test();
        stall_addr = 3;
        stall_len = 5;
        for (int p = 0; p < 64; p++) pix_q.push_back({p == 63, 4'($urandom_range(15))});
        run_idle("stall", 3000);
        n3 = 0;
        foreach (log_addr[i]) if (log_addr[i] == 3'd3) n3++;
        check("stall row3 transfers", n3, 1);

        // Row 2 never acked.
        start_test();
        noack_addr = 2;
        for (int p = 0; p < 64; p++) pix_q.push_back({p == 63, 4'($urandom_range(15))});
        run_idle("noack", 3000);
        check("noack err literal", got_err, 1 + 8 * RbErr);
        check("noack next row addr", log_addr[3], 3'd3);

        // Early last on pixel 10, then a full frame.
        start_test();
        for (int p = 0; p <= 10; p++) pix_q.push_back({p == 10, 4'(p + 2)});
        push_frame_ramp();
        run_idle("early last", 4000);
        check("early row1 word", log_data[1], 32'hABC00000);
        check("early next addr", log_addr[2], 3'd0);
        check("early done literal", got_done, 2);
        check("early err literal", got_err, 1 + 10 * RbErr);

        // Randomized frames, bus jitter and pixel gaps.
        start_test();
        stall_pct = 30;
        valid_pct = 70;
        min_dly = 0;
        max_dly = 3;
        for (int f = 0; f < 6; f++) begin
            mode = int'($urandom_range(2));
            cut = (mode == 1) ? int'($urandom_range(62)) : 63;
            for (int p = 0; p <= cut; p++)
                pix_q.push_back({(mode != 2) && (p == cut), 4'($urandom_range(15))});
        end
        run_idle("random", 30000);

        // Reset in the middle of a bus cycle.
        start_test();
        push_frame_ramp();
        for (int n = 0; n < 200 && !o_wb_cyc; n++) tick();
        check("midreset saw cyc", o_wb_cyc, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset cyc async", o_wb_cyc, 1'b0);
        check("midreset stb async", o_wb_stb, 1'b0);
        pix_q.delete();
        exp_wr.delete();
        model_pix = 0;
        model_word = 32'h0;
        pending = 0;
        tmo_pending = 0;
        prev_stalled = 0;
        cyc_run = 0;
        i_pix_valid = 1'b0;
        i_wb_ack = 1'b0;
        i_wb_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("midreset ready", o_pix_ready, 1'b1);
        start_test();
        push_frame_ramp();
        run_idle("after reset", 3000);
        check("after reset addr0", log_addr[0], 3'd0);
        check("after reset row0", log_data[0], 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
